// File: rtl/ex_mem_req_if.sv
// Data SRAM-like request/response bundle between the EX-stage issuer and memory.
// The master drives the request; the slave returns addr_ok/data_ok.
interface ex_mem_req_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size,
               data_sram_wstrb, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size,
               data_sram_wstrb, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok
    );
endinterface

// File: rtl/ex_mem_req.sv
// EX-stage load/store issuer: builds the SRAM request, owns the addr_ok handshake,
// tracks outstanding requests and drops responses that belong to flushed instructions.
module ex_mem_req #(
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_valid,
    input  logic        es_mem_re,
    input  logic        es_mem_we,
    input  logic [1:0]  es_mem_size,
    input  logic [31:0] es_vaddr,
    input  logic [31:0] es_st_data,
    input  logic        es_except,
    input  logic        except_flush,
    input  logic        ms_allowin,
    output logic        es_ready_go,
    output logic        es_ale,
    output logic        ms_data_ok,
    ex_mem_req_if.master dsram
);

    logic             w_mem_op;
    logic             w_misaligned;
    logic             w_req;
    logic             w_hs;
    logic             w_data_ok;
    logic [3:0]       w_strb_raw;
    logic [31:0]      w_wdata;
    logic [CNT_W-1:0] w_out_next;
    logic             r_req_done;
    logic [CNT_W-1:0] r_out_cnt;
    logic [CNT_W-1:0] r_cancel_cnt;

    assign w_mem_op     = es_mem_re | es_mem_we;
    assign w_data_ok    = dsram.data_sram_data_ok;
    assign w_misaligned = ((es_mem_size == 2'b01) & es_vaddr[0]) |
                          (es_mem_size[1] & (es_vaddr[1:0] != 2'b00));
    assign es_ale       = es_valid & w_mem_op & w_misaligned;

    // Gating on resetn keeps req low for the whole time reset is held.
    assign w_req = resetn & es_valid & w_mem_op & ~es_except & ~es_ale & ~except_flush &
                   ~r_req_done & (r_cancel_cnt == {CNT_W{1'b0}}) &
                   (r_out_cnt < CNT_W'(MAX_OUT));
    assign w_hs  = w_req & dsram.data_sram_addr_ok;

    assign es_ready_go = ~w_mem_op | es_except | es_ale | w_hs | r_req_done;

    // Everything in flight at a flush is younger than the flushing instruction,
    // so a response landing in the flush cycle is dropped as well.
    assign ms_data_ok = resetn & w_data_ok & (r_cancel_cnt == {CNT_W{1'b0}}) & ~except_flush;

    // Byte strobes and lane-replicated store data by access size.
    always_comb begin
        w_strb_raw = 4'b1111;
        w_wdata    = es_st_data;
        case (es_mem_size)
            2'b00: begin
                w_strb_raw = 4'b0001 << es_vaddr[1:0];
                w_wdata    = {4{es_st_data[7:0]}};
            end
            2'b01: begin
                w_strb_raw = es_vaddr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{es_st_data[15:0]}};
            end
            default: begin
                w_strb_raw = 4'b1111;
                w_wdata    = es_st_data;
            end
        endcase
    end

    assign dsram.data_sram_req   = w_req;
    assign dsram.data_sram_wr    = es_mem_we;
    assign dsram.data_sram_size  = es_mem_size;
    assign dsram.data_sram_addr  = es_vaddr;
    assign dsram.data_sram_wdata = w_wdata;
    assign dsram.data_sram_wstrb = es_mem_we ? w_strb_raw : 4'b0000;

    // Next outstanding count; a stray data_ok at zero saturates.
    always_comb begin
        w_out_next = r_out_cnt;
        if (w_hs && !w_data_ok) begin
            w_out_next = r_out_cnt + CNT_W'(1);
        end else if (!w_hs && w_data_ok && (r_out_cnt != {CNT_W{1'b0}})) begin
            w_out_next = r_out_cnt - CNT_W'(1);
        end else begin
            w_out_next = r_out_cnt;
        end
    end

    // Outstanding-request counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_cnt <= {CNT_W{1'b0}};
        end else begin
            r_out_cnt <= w_out_next;
        end
    end

    // Responses still owed to flushed instructions; a flush never coincides with hs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cancel_cnt <= {CNT_W{1'b0}};
        end else if (except_flush) begin
            r_cancel_cnt <= w_out_next;
        end else if (w_data_ok && (r_cancel_cnt != {CNT_W{1'b0}})) begin
            r_cancel_cnt <= r_cancel_cnt - CNT_W'(1);
        end else begin
            r_cancel_cnt <= r_cancel_cnt;
        end
    end

    // Marks that the instruction held in EX already has its request in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req_done <= 1'b0;
        end else if (except_flush) begin
            r_req_done <= 1'b0;
        end else if (es_valid && es_ready_go && ms_allowin) begin
            r_req_done <= 1'b0;
        end else if (w_hs && !ms_allowin) begin
            r_req_done <= 1'b1;
        end else begin
            r_req_done <= r_req_done;
        end
    end

endmodule

// File: tb/tb_ex_mem_req.sv
// Randomized bench for ex_mem_req: directed literal checks, then random traffic
// compared every cycle against a queue-based model of in-flight requests.
module tb_ex_mem_req;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        es_valid = 1'b0, es_mem_re = 1'b0, es_mem_we = 1'b0;
    logic [1:0]  es_mem_size = 2'b00;
    logic [31:0] es_vaddr = 32'h0, es_st_data = 32'h0;
    logic        es_except = 1'b0, except_flush = 1'b0, ms_allowin = 1'b0;
    logic        es_ready_go, es_ale, ms_data_ok;

    int total = 0;
    int bad   = 0;

    // model state: one entry per accepted request, 1 = response still wanted
    bit q[$];
    bit m_issued = 1'b0;
    bit m_adv    = 1'b0;

    ex_mem_req_if dsram ();

    ex_mem_req #(.MAX_OUT(MAX_OUT), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn), .es_valid(es_valid), .es_mem_re(es_mem_re),
        .es_mem_we(es_mem_we), .es_mem_size(es_mem_size), .es_vaddr(es_vaddr),
        .es_st_data(es_st_data), .es_except(es_except), .except_flush(except_flush),
        .ms_allowin(ms_allowin), .es_ready_go(es_ready_go), .es_ale(es_ale),
        .ms_data_ok(ms_data_ok), .dsram(dsram)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Reference model: compares at the falling edge, then advances to the next rising edge.
    always @(negedge clk) begin
        bit          mem_op, misal, e_ale, e_req, e_hs, e_rg, e_ms, aok, dok;
        int          dead;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        if (!resetn) begin
            chk("rst_req", {31'd0, dsram.data_sram_req}, 32'd0);
            chk("rst_msok", {31'd0, ms_data_ok}, 32'd0);
            q.delete();
            m_issued = 1'b0;
            m_adv    = 1'b0;
        end else begin
            aok    = dsram.data_sram_addr_ok;
            dok    = dsram.data_sram_data_ok;
            mem_op = es_mem_re || es_mem_we;
            misal  = (es_mem_size == 2'd1 && es_vaddr[0]) ||
                     (es_mem_size >= 2'd2 && (es_vaddr % 4) != 0);
            e_ale  = es_valid && mem_op && misal;
            dead = 0;
            foreach (q[i]) if (!q[i]) dead++;
            e_req = es_valid && mem_op && !es_except && !e_ale && !except_flush &&
                    !m_issued && dead == 0 && q.size() < MAX_OUT;
            e_hs  = e_req && aok;
            e_rg  = !mem_op || es_except || e_ale || e_hs || m_issued;
            e_ms  = dok && !except_flush && q.size() > 0 && q[0];
            case (es_mem_size)
                2'd0: begin
                    e_strb  = 4'(1 << (es_vaddr % 4));
                    e_wdata = es_st_data[7:0] * 32'h01010101;
                end
                2'd1: begin
                    e_strb  = 4'(3 << (es_vaddr % 4 & 2));
                    e_wdata = es_st_data[15:0] * 32'h00010001;
                end
                default: begin
                    e_strb  = 4'hf;
                    e_wdata = es_st_data;
                end
            endcase
            if (!es_mem_we) e_strb = 4'h0;

            chk("req", {31'd0, dsram.data_sram_req}, {31'd0, e_req});
            chk("ale", {31'd0, es_ale}, {31'd0, e_ale});
            chk("rdy", {31'd0, es_ready_go}, {31'd0, e_rg});
            chk("msok", {31'd0, ms_data_ok}, {31'd0, e_ms});
            chk("wr", {31'd0, dsram.data_sram_wr}, {31'd0, es_mem_we});
            chk("size", {30'd0, dsram.data_sram_size}, {30'd0, es_mem_size});
            chk("addr", dsram.data_sram_addr, es_vaddr);
            chk("wstrb", {28'd0, dsram.data_sram_wstrb}, {28'd0, e_strb});
            if (e_req && es_mem_we) chk("wdata", dsram.data_sram_wdata, e_wdata);

            if (except_flush) foreach (q[i]) q[i] = 1'b0;
            if (dok && q.size() > 0) void'(q.pop_front());
            if (e_hs) q.push_back(1'b1);
            m_adv = es_valid && e_rg && ms_allowin;
            if (except_flush || m_adv) m_issued = 1'b0;
            else if (e_hs)             m_issued = 1'b1;
        end
    end

    task automatic set_in(input logic v, input logic re, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input logic exc,
                          input logic fl, input logic al, input logic aok, input logic dok);
        @(posedge clk);
        #1;
        es_valid = v; es_mem_re = re; es_mem_we = we; es_mem_size = sz;
        es_vaddr = a; es_st_data = d; es_except = exc; except_flush = fl;
        ms_allowin = al; dsram.data_sram_addr_ok = aok; dsram.data_sram_data_ok = dok;
        #1;
    endtask

    initial begin
        dsram.data_sram_addr_ok = 1'b0;
        dsram.data_sram_data_ok = 1'b0;
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        chk("d_rst_req", {31'd0, dsram.data_sram_req}, 32'd0);
        resetn = 1'b1;

        // st.b to 0x1003 accepted immediately
        set_in(1, 0, 1, 2'd0, 32'h1003, 32'h12345678, 0, 0, 1, 1, 0);
        chk("d_stb_req", {31'd0, dsram.data_sram_req}, 32'd1);
        chk("d_stb_wr", {31'd0, dsram.data_sram_wr}, 32'd1);
        chk("d_stb_size", {30'd0, dsram.data_sram_size}, 32'd0);
        chk("d_stb_wstrb", {28'd0, dsram.data_sram_wstrb}, 32'h8);
        chk("d_stb_wdata", dsram.data_sram_wdata, 32'h78787878);
        chk("d_stb_rdy", {31'd0, es_ready_go}, 32'd1);
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 1, 0, 1);
        chk("d_stb_msok", {31'd0, ms_data_ok}, 32'd1);

        // misaligned ld.h, then aligned ld.w
        set_in(1, 1, 0, 2'd1, 32'h2001, 32'h0, 0, 0, 1, 1, 0);
        chk("d_ldh_ale", {31'd0, es_ale}, 32'd1);
        chk("d_ldh_req", {31'd0, dsram.data_sram_req}, 32'd0);
        chk("d_ldh_rdy", {31'd0, es_ready_go}, 32'd1);
        set_in(1, 1, 0, 2'd2, 32'h2004, 32'h0, 0, 0, 1, 1, 0);
        chk("d_ldw_req", {31'd0, dsram.data_sram_req}, 32'd1);
        chk("d_ldw_wr", {31'd0, dsram.data_sram_wr}, 32'd0);
        chk("d_ldw_wstrb", {28'd0, dsram.data_sram_wstrb}, 32'd0);
        chk("d_ldw_size", {30'd0, dsram.data_sram_size}, 32'd2);
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 1, 0, 1);

        // store accepted while MEM is blocked: no re-issue
        set_in(1, 0, 1, 2'd2, 32'h3000, 32'hcafef00d, 0, 0, 0, 1, 0);
        chk("d_hold_req0", {31'd0, dsram.data_sram_req}, 32'd1);
        set_in(1, 0, 1, 2'd2, 32'h3000, 32'hcafef00d, 0, 0, 0, 1, 0);
        chk("d_hold_req1", {31'd0, dsram.data_sram_req}, 32'd0);
        chk("d_hold_rdy1", {31'd0, es_ready_go}, 32'd1);
        set_in(1, 0, 1, 2'd2, 32'h3000, 32'hcafef00d, 0, 0, 1, 0, 0);
        chk("d_hold_rdy2", {31'd0, es_ready_go}, 32'd1);
        set_in(1, 0, 1, 2'd2, 32'h3004, 32'h1, 0, 0, 1, 0, 0);
        chk("d_hold_clr", {31'd0, dsram.data_sram_req}, 32'd1);
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 1, 0, 1);

        // outstanding limit
        set_in(1, 1, 0, 2'd2, 32'h100, 32'h0, 0, 0, 1, 1, 0);
        set_in(1, 1, 0, 2'd2, 32'h104, 32'h0, 0, 0, 1, 1, 0);
        set_in(1, 1, 0, 2'd2, 32'h108, 32'h0, 0, 0, 1, 1, 0);
        chk("d_full_req", {31'd0, dsram.data_sram_req}, 32'd0);
        chk("d_full_rdy", {31'd0, es_ready_go}, 32'd0);
        set_in(1, 1, 0, 2'd2, 32'h108, 32'h0, 0, 0, 1, 1, 1);
        chk("d_full_req2", {31'd0, dsram.data_sram_req}, 32'd0);
        chk("d_full_msok", {31'd0, ms_data_ok}, 32'd1);
        set_in(1, 1, 0, 2'd2, 32'h108, 32'h0, 0, 0, 1, 1, 0);
        chk("d_free_req", {31'd0, dsram.data_sram_req}, 32'd1);

        // asynchronous reset while stalled with two outstanding
        set_in(1, 1, 0, 2'd2, 32'h10c, 32'h0, 0, 0, 1, 1, 0);
        chk("d_stall_req", {31'd0, dsram.data_sram_req}, 32'd0);
        #1 resetn = 1'b0;
        #1;
        chk("d_arst_req", {31'd0, dsram.data_sram_req}, 32'd0);
        chk("d_arst_out", {30'd0, dut.r_out_cnt}, 32'd0);
        chk("d_arst_cancel", {30'd0, dut.r_cancel_cnt}, 32'd0);
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        resetn = 1'b1;

        // flush with one load in flight
        set_in(1, 1, 0, 2'd2, 32'h200, 32'h0, 0, 0, 1, 1, 0);
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 1, 0, 0);
        set_in(1, 1, 0, 2'd2, 32'h204, 32'h0, 0, 0, 1, 1, 1);
        chk("d_fl_drop", {31'd0, ms_data_ok}, 32'd0);
        chk("d_fl_block", {31'd0, dsram.data_sram_req}, 32'd0);
        set_in(1, 1, 0, 2'd2, 32'h204, 32'h0, 0, 0, 1, 1, 0);
        chk("d_fl_req", {31'd0, dsram.data_sram_req}, 32'd1);
        set_in(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 1, 0, 1);
        chk("d_fl_live", {31'd0, ms_data_ok}, 32'd1);

        // random traffic; EX holds an instruction until it advances or is flushed
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            if (!es_valid || m_adv || except_flush) begin
                int op;
                op          = $urandom_range(0, 2);
                es_valid    = ($urandom_range(0, 4) != 0);
                es_mem_re   = (op == 1);
                es_mem_we   = (op == 2);
                es_mem_size = 2'($urandom_range(0, 3));
                es_vaddr    = $urandom;
                if ($urandom_range(0, 1) == 0) es_vaddr[1:0] = 2'b00;
                es_st_data  = $urandom;
                es_except   = ($urandom_range(0, 15) == 0);
            end
            except_flush = ($urandom_range(0, 24) == 0);
            ms_allowin   = ($urandom_range(0, 3) != 0);
            dsram.data_sram_addr_ok = ($urandom_range(0, 9) < 6);
            dsram.data_sram_data_ok = (q.size() > 0) && ($urandom_range(0, 9) < 4);
        end
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
